// File: rtl/serial_link_obi_arbiter.sv
// Round-robin arbiter of NumReq OBI requesters onto one serial-link OBI port,
// with an ID FIFO that routes responses back to the issuing requester in grant order.
module serial_link_obi_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  output logic [NumReq-1:0]                     gnt_o,
  output logic [NumReq-1:0]                     rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  mst_req_o,
  output logic [AddrWidth-1:0]                  mst_addr_o,
  output logic                                  mst_we_o,
  output logic [DataWidth/8-1:0]                mst_be_o,
  output logic [DataWidth-1:0]                  mst_wdata_o,
  input  logic                                  mst_gnt_i,
  input  logic                                  mst_rvalid_i,
  input  logic [DataWidth-1:0]                  mst_rdata_i,
  output logic [$clog2(MaxOutstanding):0]       outstanding_o,
  output logic                                  err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e            r_state;
  logic [IdxW-1:0]   r_rr_ptr;
  logic [IdxW-1:0]   r_hold_idx;
  logic [IdxW-1:0]   r_fifo [MaxOutstanding];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;
  logic              r_err;

  logic [IdxW-1:0]   w_rr_sel;
  logic              w_found;
  logic [IdxW-1:0]   w_sel;
  logic              w_pop;
  logic              w_space;
  logic              w_req;
  logic              w_hs;
  logic [IdxW-1:0]   w_rr_next;

  // Round-robin search starting at r_rr_ptr, wrapping modulo NumReq
  always_comb begin : rr_search
    int j;
    w_rr_sel = r_rr_ptr;
    w_found  = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) begin
      j = (int'(r_rr_ptr) + i) % int'(NumReq);
      if (!w_found && req_i[j]) begin
        w_found  = 1'b1;
        w_rr_sel = IdxW'(j);
      end
    end
  end

  // A response popping this cycle frees a slot, so a full FIFO can still accept a push
  assign w_sel     = (r_state == S_HOLD) ? r_hold_idx : w_rr_sel;
  assign w_pop     = ~rst_i & mst_rvalid_i & (r_count != '0);
  assign w_space   = (r_count != CntW'(MaxOutstanding)) | w_pop;
  assign w_req     = ~rst_i & w_space & ((r_state == S_HOLD) | (|req_i));
  assign w_hs      = w_req & mst_gnt_i;
  assign w_rr_next = (w_sel == IdxW'(NumReq - 1)) ? '0 : w_sel + IdxW'(1);

  assign mst_req_o     = w_req;
  assign mst_addr_o    = addr_i[w_sel];
  assign mst_we_o      = we_i[w_sel];
  assign mst_be_o      = be_i[w_sel];
  assign mst_wdata_o   = wdata_i[w_sel];
  assign rdata_o       = mst_rdata_i;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (w_hs)  gnt_o[w_sel]            = 1'b1;
    if (w_pop) rvalid_o[r_fifo[r_rptr]] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_hold_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= r_wptr + PtrW'(1);
        r_rr_ptr       <= w_rr_next;
      end
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (mst_rvalid_i && (r_count == '0)) r_err <= 1'b1;
      case (r_state)
        S_IDLE: if (w_req && !mst_gnt_i) begin
          r_hold_idx <= w_sel;
          r_state    <= S_HOLD;
        end
        S_HOLD: if (w_hs) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_link_obi_arbiter.md
SERIAL_LINK_OBI_ARBITER -- requirements
Module: serial_link_obi_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i is the only clock; rst_i is sampled on rising clk_i.
REQ-002 Parameter NumReq, default 2, SHALL set the number of OBI requesters (range 2..8).
REQ-003 Parameter AddrWidth, default 32, SHALL set the OBI address width.
REQ-004 Parameter DataWidth, default 32, SHALL set the OBI data width; the byte-enable width is DataWidth/8.
REQ-005 Parameter MaxOutstanding, default 4, SHALL set the depth of the response-routing ID FIFO (power of 2, at least 2).
REQ-006 The ports SHALL be as follows:
- clk_i  in  1  clock
- rst_i  in  1  sync active-high reset
- req_i  in  [NumReq]  per-requester OBI req
- addr_i  in  [NumReq][AddrWidth]  per-requester address
- we_i  in  [NumReq]  per-requester write enable
- be_i  in  [NumReq][DataWidth/8]  per-requester byte enable
- wdata_i  in  [NumReq][DataWidth]  per-requester write data
- gnt_o  out  [NumReq]  per-requester grant
- rvalid_o  out  [NumReq]  per-requester response valid
- rdata_o  out  [DataWidth]  response data, shared by all requesters
- mst_req_o  out  1  request to the serial-link OBI slave port
- mst_addr_o, mst_we_o, mst_be_o, mst_wdata_o  out  (as above)  muxed request payload
- mst_gnt_i  in  1  slave grant
- mst_rvalid_i  in  1  slave response valid
- mst_rdata_i  in  [DataWidth]  slave response data
- outstanding_o  out  [$clog2(MaxOutstanding)+1]  count of issued, unanswered transactions
- err_o  out  1  sticky error: response received with no outstanding transaction

Function
REQ-007 The arbiter SHALL use round-robin priority: the search starts at rr_ptr and wraps modulo NumReq; the lowest index at or after rr_ptr with req_i set wins.
REQ-008 The FSM SHALL have two states, IDLE and HOLD:
- IDLE: when any req_i is set and the ID FIFO is not full, assert mst_req_o for the winner.
- If mst_gnt_i is low in that cycle, latch the winner index and go to HOLD.
REQ-009 In HOLD, the FSM SHALL keep the latched index selected and assert mst_req_o until mst_gnt_i, regardless of other req_i changes; on mst_gnt_i it returns to IDLE.
REQ-010 The mst_addr/we/be/wdata outputs SHALL be combinationally muxed from the selected requester (the IDLE winner or the HOLD index).
REQ-011 The grant path SHALL be combinational: gnt_o[sel] = mst_req_o & mst_gnt_i; all other gnt_o bits are 0.
REQ-012 A handshake is mst_req_o & mst_gnt_i; on each handshake:
- push sel into the ID FIFO;
- set rr_ptr to (sel+1) mod NumReq.
REQ-013 When the ID FIFO is full, mst_req_o SHALL be 0 and no grant is given; a requester held in HOLD keeps HOLD state with mst_req_o low until space frees.
REQ-014 On mst_rvalid_i with the FIFO non-empty, the block SHALL:
- assert rvalid_o[head ID] in the same cycle;
- drive rdata_o = mst_rdata_i;
- pop the FIFO.
REQ-015 When no response is being routed, rdata_o SHALL pass mst_rdata_i through unchanged and every rvalid_o bit SHALL be 0.
REQ-016 A push and a pop in the same cycle SHALL leave the occupancy unchanged and SHALL be legal even when the FIFO is full.
REQ-017 mst_rvalid_i with the FIFO empty SHALL:
- set err_o;
- assert no rvalid_o;
- leave the FIFO pointers unchanged.
REQ-018 When the FIFO is empty, a push in the same cycle SHALL NOT satisfy an mst_rvalid_i in that cycle; responses arrive at the earliest one cycle after the grant.
REQ-019 outstanding_o SHALL equal the FIFO occupancy, in the range 0..MaxOutstanding.
REQ-020 Order SHALL be preserved: responses are routed strictly in grant order.

Reset
REQ-021 While rst_i is high, the block SHALL set state=IDLE, rr_ptr=0, FIFO pointers and occupancy=0, and err_o=0.
REQ-022 During reset, mst_req_o and all gnt_o and rvalid_o bits SHALL be 0.
REQ-023 A reset asserted mid-transaction SHALL discard all outstanding IDs; a late mst_rvalid_i after reset SHALL set err_o.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Scenario 1: req_i=2'b11 continuously, mst_gnt_i=1, rvalid one cycle later -> grants alternate 0,1,0,1; rvalid_o follows the same order; outstanding_o stays at most 1.
- Scenario 2: req_i[0]=1, mst_gnt_i=0 for 3 cycles, then req_i[1] rises -> the address stays at req0's address (e.g. 0x1000_0000); gnt_o=2'b01 when mst_gnt_i rises.
- Scenario 3: MaxOutstanding=4, 4 grants with no rvalid -> outstanding_o=4 and mst_req_o=0; one rvalid -> outstanding_o=3 and the next grant issues.
- Scenario 4: full FIFO, handshake and mst_rvalid_i in the same cycle -> outstanding_o stays 4; rvalid_o goes to the oldest ID.
- Scenario 5: mst_rvalid_i with outstanding_o=0 -> err_o=1 and stays 1 until rst_i; rvalid_o=0.
- Scenario 6: 2 outstanding, then rst_i pulsed for 1 cycle -> outstanding_o=0, rr_ptr=0, and the next req_i=2'b11 grants requester 0.
